// File: rtl/signmag_seq_multiplier.sv
// Sequential shift-add multiplier on sign-magnitude operands.
// Produces a 2N-bit unsigned product magnitude plus a separate sign bit.
// One product takes N CALC cycles followed by a one-cycle DONE pulse.
// Results are held between operations and cleared only by reset.
module signmag_seq_multiplier #(
  parameter int N = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_a_mag,
  input  logic           i_a_sign,
  input  logic [N-1:0]   i_b_mag,
  input  logic           i_b_sign,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_prod_mag,
  output logic           o_prod_sign
);

  // Counter must be able to hold N-1 (it may wrap after the last step).
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplr;
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic [2*N-1:0]   r_prod_mag;
  logic             r_prod_sign;

  logic             w_accept;
  logic             w_last;
  logic [2*N-1:0]   w_acc_nxt;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_last    = (r_state == S_CALC) && (r_cnt == CW'(N - 1));
  // Cannot overflow: (2^N-1)^2 < 2^2N.
  assign w_acc_nxt = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: start only matters in IDLE; DONE always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift-add step per CALC cycle,
  // result registers written only on the final CALC edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_prod_mag  <= '0;
      r_prod_sign <= 1'b0;
    end else if (w_accept) begin
      r_mcand <= {{N{1'b0}}, i_a_mag};
      r_mplr  <= i_b_mag;
      r_sign  <= i_a_sign ^ i_b_sign;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_prod_mag  <= w_acc_nxt;
        // No negative zero.
        r_prod_sign <= r_sign & (|w_acc_nxt);
      end
    end
  end

  // Status decodes straight from the state register: no input-to-output path.
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_prod_mag  = r_prod_mag;
  assign o_prod_sign = r_prod_sign;

endmodule

// File: tb/tb_signmag_seq_multiplier.sv
// Directed bench for signmag_seq_multiplier (N=5): vector table plus
// hand-written sequences for ignored start, mid-op reset and back-to-back.
module tb_signmag_seq_multiplier;

  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           i_start;
  logic [N-1:0]   i_a_mag;
  logic           i_a_sign;
  logic [N-1:0]   i_b_mag;
  logic           i_b_sign;
  logic           o_busy;
  logic           o_done;
  logic [2*N-1:0] o_prod_mag;
  logic           o_prod_sign;

  int n_cmp;
  int n_err;
  int prev_mag;
  int prev_sign;

  typedef struct {
    logic [N-1:0]   a;
    logic           as;
    logic [N-1:0]   b;
    logic           bs;
    logic [2*N-1:0] pm;
    logic           ps;
  } vec_t;

  vec_t vt[10];

  signmag_seq_multiplier #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (i_start),
    .i_a_mag     (i_a_mag),
    .i_a_sign    (i_a_sign),
    .i_b_mag     (i_b_mag),
    .i_b_sign    (i_b_sign),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_prod_mag  (o_prod_mag),
    .o_prod_sign (o_prod_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_ops();
    i_a_mag  = N'($urandom);
    i_b_mag  = N'($urandom);
    i_a_sign = 1'($urandom);
    i_b_sign = 1'($urandom);
  endtask

  task automatic chk_held(input string name);
    chk({name, "_mag_held"},  int'(o_prod_mag),  prev_mag);
    chk({name, "_sign_held"}, int'(o_prod_sign), prev_sign);
  endtask

  // Called just after an edge with the DUT in IDLE; returns just after the
  // DONE->IDLE edge.
  task automatic do_op(input string name,
                       input logic [N-1:0] a, input logic as,
                       input logic [N-1:0] b, input logic bs,
                       input int em, input int es);
    i_a_mag = a; i_a_sign = as; i_b_mag = b; i_b_sign = bs;
    i_start = 1'b1;
    tick();                             // E0
    i_start = 1'b0;
    scramble_ops();
    for (int k = 0; k < N; k++) begin   // cycles after E0 .. E0+N-1
      chk({name, "_busy_calc"}, int'(o_busy), 1);
      chk({name, "_done_early"}, int'(o_done), 0);
      chk_held({name, "_calc"});
      tick();
    end
    chk({name, "_done"}, int'(o_done), 1);
    chk({name, "_busy_done"}, int'(o_busy), 1);
    chk({name, "_mag"}, int'(o_prod_mag), em);
    chk({name, "_sign"}, int'(o_prod_sign), es);
    prev_mag = em; prev_sign = es;
    tick();
    chk({name, "_done_fall"}, int'(o_done), 0);
    chk({name, "_busy_fall"}, int'(o_busy), 0);
    chk_held({name, "_idle"});
  endtask

  initial begin
    int conv;
    n_cmp = 0; n_err = 0;
    prev_mag = 0; prev_sign = 0;
    i_start = 1'b0;
    i_a_mag = '0; i_a_sign = 1'b0; i_b_mag = '0; i_b_sign = 1'b0;

    vt[0] = '{5'd13, 1'b0, 5'd11, 1'b1, 10'd143, 1'b1};
    vt[1] = '{5'd31, 1'b1, 5'd31, 1'b1, 10'd961, 1'b0};
    vt[2] = '{5'd0,  1'b0, 5'd7,  1'b1, 10'd0,   1'b0};
    vt[3] = '{5'd2,  1'b0, 5'd3,  1'b0, 10'd6,   1'b0};
    vt[4] = '{5'd5,  1'b0, 5'd3,  1'b1, 10'd15,  1'b1};
    vt[5] = '{5'd4,  1'b1, 5'd4,  1'b1, 10'd16,  1'b0};
    vt[6] = '{5'd1,  1'b1, 5'd1,  1'b0, 10'd1,   1'b1};
    vt[7] = '{5'd31, 1'b0, 5'd1,  1'b1, 10'd31,  1'b1};
    vt[8] = '{5'd7,  1'b1, 5'd0,  1'b0, 10'd0,   1'b0};
    vt[9] = '{5'd16, 1'b0, 5'd16, 1'b0, 10'd256, 1'b0};

    // Reset values, no clock edge yet.
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_mag",  int'(o_prod_mag), 0);
    chk("rst_sign", int'(o_prod_sign), 0);
    #2;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", int'(o_busy), 0);

    // Table.
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].as, vt[i].b, vt[i].bs,
            int'(vt[i].pm), int'(vt[i].ps));

    // Downstream converter view of 13 x (-11): 2N-bit two's complement.
    do_op("basic", 5'd13, 1'b0, 5'd11, 1'b1, 143, 1);
    conv = o_prod_sign ? ((1 << (2*N)) - int'(o_prod_mag)) % (1 << (2*N))
                       : int'(o_prod_mag);
    chk("basic_conv", conv, 881);
    tick(); tick();
    chk_held("basic_hold");

    // Ignored start in CALC cycles 2 and 4 and in the DONE cycle.
    i_a_mag = 5'd13; i_a_sign = 1'b0; i_b_mag = 5'd11; i_b_sign = 1'b1;
    i_start = 1'b1;
    tick();                             // E0, now in CALC cycle 1
    i_start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      chk("ign_done_early", int'(o_done), 0);
      chk("ign_busy", int'(o_busy), 1);
      i_start = (c == 2 || c == 4);
      i_a_mag = 5'd3; i_b_mag = 5'd3; i_a_sign = 1'b1; i_b_sign = 1'b0;
      tick();
    end
    chk("ign_done", int'(o_done), 1);
    chk("ign_mag", int'(o_prod_mag), 143);
    chk("ign_sign", int'(o_prod_sign), 1);
    prev_mag = 143; prev_sign = 1;
    i_start = 1'b1;                     // in DONE cycle: must be dropped
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ign_idle_busy", int'(o_busy), 0);
      chk("ign_idle_done", int'(o_done), 0);
      chk_held("ign_idle");
      tick();
    end

    // Reset during CALC cycle 3 of 6 x 6.
    i_a_mag = 5'd6; i_a_sign = 1'b0; i_b_mag = 5'd6; i_b_sign = 1'b0;
    i_start = 1'b1;
    tick();                             // E0 -> CALC cycle 1
    i_start = 1'b0;
    tick(); tick();                     // CALC cycle 3
    chk("mid_busy_pre", int'(o_busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_done", int'(o_done), 0);
    chk("mid_rst_mag",  int'(o_prod_mag), 0);
    chk("mid_rst_sign", int'(o_prod_sign), 0);
    prev_mag = 0; prev_sign = 0;
    #2;
    tick();
    rst = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      tick();
      chk("mid_no_done", int'(o_done), 0);
      chk("mid_idle", int'(o_busy), 0);
    end
    do_op("after_rst", 5'd2, 1'b0, 5'd3, 1'b0, 6, 0);

    // Back-to-back with start held: accepts at E0 and E0+N+2.
    i_a_mag = 5'd5; i_a_sign = 1'b0; i_b_mag = 5'd3; i_b_sign = 1'b1;
    i_start = 1'b1;
    tick();                             // E0
    i_a_mag = 5'd4; i_a_sign = 1'b1; i_b_mag = 5'd4; i_b_sign = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("b2b_busy1", int'(o_busy), 1);
      chk("b2b_done1_early", int'(o_done), 0);
      tick();
    end
    chk("b2b_done1", int'(o_done), 1);
    chk("b2b_mag1", int'(o_prod_mag), 15);
    chk("b2b_sign1", int'(o_prod_sign), 1);
    tick();                             // E0+N+1: the single IDLE cycle
    chk("b2b_gap_busy", int'(o_busy), 0);
    chk("b2b_gap_done", int'(o_done), 0);
    tick();                             // E0+N+2: second accept
    i_start = 1'b0;
    scramble_ops();
    chk("b2b_accept2_busy", int'(o_busy), 1);
    for (int k = 0; k < N - 1; k++) begin
      tick();
      chk("b2b_busy2", int'(o_busy), 1);
      chk("b2b_done2_early", int'(o_done), 0);
      chk("b2b_hold1", int'(o_prod_mag), 15);
    end
    tick();
    chk("b2b_done2", int'(o_done), 1);
    chk("b2b_mag2", int'(o_prod_mag), 16);
    chk("b2b_sign2", int'(o_prod_sign), 0);
    tick();
    chk("b2b_end_busy", int'(o_busy), 0);
    chk("b2b_end_done", int'(o_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
